// File: rtl/antiprobe_pkg.sv
// Shared constants and types for the comparator-to-GTH framing path.
package antiprobe_pkg;

  localparam int unsigned DATA_W         = 80;
  localparam int unsigned HDR_W          = 8;
  localparam int unsigned PAYLOAD_W      = 72;
  localparam int unsigned NUM_CH         = 4;
  localparam int unsigned BEATS_PER_WORD = 18;

  localparam logic [HDR_W-1:0] HDR_DATA   = 8'hD5;
  localparam logic [HDR_W-1:0] HDR_IDLE   = 8'h3C;
  localparam logic [HDR_W-1:0] HDR_ALIGN  = 8'hBC;
  localparam logic [7:0]       ALIGN_BYTE = 8'hBC;

  // Which word the output register loads this cycle.
  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_ALIGN,
    SEL_DATA
  } word_sel_e;

endpackage

// File: rtl/cmp_gth_framer_collector.sv
// Collects masked comparator beats into a 72-bit payload; pulses payload_done
// on the edge that accepts the 18th beat.
module cmp_beat_collector
  import antiprobe_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 cmp_valid,
  input  logic [NUM_CH-1:0]    cmp_data,
  input  logic [NUM_CH-1:0]    ch_mask,
  output logic [4:0]           beat_cnt,
  output logic [PAYLOAD_W-1:0] payload,
  output logic                 payload_done
);

  logic [4:0]           beat_cnt_q, beat_cnt_d;
  logic [PAYLOAD_W-1:0] shift_q, shift_d;
  logic [NUM_CH-1:0]    beat;

  // Beat placement and count; stale nibbles are simply overwritten by the next word,
  // so enable low only needs to rewind the position.
  always_comb begin
    beat         = cmp_data & ch_mask;
    beat_cnt_d   = beat_cnt_q;
    shift_d      = shift_q;
    payload_done = 1'b0;
    if (!enable) begin
      beat_cnt_d = '0;
    end else if (cmp_valid) begin
      shift_d[NUM_CH*beat_cnt_q +: NUM_CH] = beat;
      if (beat_cnt_q == 5'(BEATS_PER_WORD - 1)) begin
        beat_cnt_d   = '0;
        payload_done = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 5'd1;
      end
    end
    payload = shift_d;
  end

  // Collector state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      shift_q    <= shift_d;
    end
  end

  assign beat_cnt = beat_cnt_q;

endmodule

// File: rtl/cmp_gth_framer.sv
// Packs comparator beats into 80-bit GTH frames: data, idle and periodic align words.
module cmp_gth_framer #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DATA_W       = 80,
  parameter int unsigned ALIGN_PERIOD = 1024
) (
  input  logic              ref_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              tx_ready,
  input  logic              cmp_valid,
  input  logic [NUM_CH-1:0] cmp_data,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [DATA_W-1:0] GTH_DATA,
  output logic              word_is_data,
  output logic [15:0]       word_cnt,
  output logic              overflow,
  output logic [4:0]        beat_cnt
);
  import antiprobe_pkg::*;

  localparam int unsigned      AW         = $clog2(ALIGN_PERIOD);
  localparam logic [AW-1:0]    ALIGN_LAST = AW'(ALIGN_PERIOD - 1);

  logic [PAYLOAD_W-1:0] payload;
  logic                 payload_done;

  logic [PAYLOAD_W-1:0] pend_q, pend_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [AW-1:0]        align_cnt_q, align_cnt_d;
  logic [DATA_W-1:0]    gth_q, gth_d;
  logic                 is_data_q, is_data_d;
  logic [15:0]          word_cnt_q, word_cnt_d;
  logic                 overflow_q, overflow_d;
  word_sel_e            sel;

  cmp_beat_collector u_collector (
    .clk          (ref_clk),
    .reset        (reset),
    .enable       (enable),
    .cmp_valid    (cmp_valid),
    .cmp_data     (cmp_data),
    .ch_mask      (ch_mask),
    .beat_cnt     (beat_cnt),
    .payload      (payload),
    .payload_done (payload_done)
  );

  // Output word selection, pending buffer handoff and counters.
  always_comb begin
    sel          = SEL_IDLE;
    align_cnt_d  = align_cnt_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    word_cnt_d   = word_cnt_q;
    overflow_d   = overflow_q;
    gth_d        = {HDR_IDLE, word_cnt_q, 56'h0};
    is_data_d    = 1'b0;

    if (tx_ready) begin
      align_cnt_d = (align_cnt_q == ALIGN_LAST) ? '0 : align_cnt_q + AW'(1);
      if (align_cnt_q == ALIGN_LAST) begin
        sel = SEL_ALIGN;
      end else if (pend_valid_q) begin
        sel = SEL_DATA;
      end
    end

    unique case (sel)
      SEL_ALIGN: gth_d = {HDR_ALIGN, {9{ALIGN_BYTE}}};
      SEL_DATA: begin
        gth_d        = {HDR_DATA, pend_q};
        is_data_d    = 1'b1;
        pend_valid_d = 1'b0;
        word_cnt_d   = word_cnt_q + 16'd1;
      end
      default: ;
    endcase

    // A drain in the same cycle frees the slot for the new payload.
    if (payload_done) begin
      if (!pend_valid_q || sel == SEL_DATA) begin
        pend_d       = payload;
        pend_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // Framer state and registered output.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      align_cnt_q  <= '0;
      gth_q        <= {HDR_IDLE, {PAYLOAD_W{1'b0}}};
      is_data_q    <= 1'b0;
      word_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      align_cnt_q  <= align_cnt_d;
      gth_q        <= gth_d;
      is_data_q    <= is_data_d;
      word_cnt_q   <= word_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign GTH_DATA     = gth_q;
  assign word_is_data = is_data_q;
  assign word_cnt     = word_cnt_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_cmp_gth_framer.sv
// Scoreboard bench for cmp_gth_framer with a short alignment period.
module tb_cmp_gth_framer;
  import antiprobe_pkg::*;

  localparam int unsigned AP = 8;

  logic        clk = 1'b0;
  logic        reset, enable, tx_ready, cmp_valid;
  logic [3:0]  cmp_data, ch_mask;
  logic [79:0] GTH_DATA;
  logic        word_is_data, overflow;
  logic [15:0] word_cnt;
  logic [4:0]  beat_cnt;

  always #5 clk = ~clk;

  cmp_gth_framer #(.NUM_CH(4), .DATA_W(80), .ALIGN_PERIOD(AP)) dut (
    .ref_clk      (clk),
    .reset        (reset),
    .enable       (enable),
    .tx_ready     (tx_ready),
    .cmp_valid    (cmp_valid),
    .cmp_data     (cmp_data),
    .ch_mask      (ch_mask),
    .GTH_DATA     (GTH_DATA),
    .word_is_data (word_is_data),
    .word_cnt     (word_cnt),
    .overflow     (overflow),
    .beat_cnt     (beat_cnt)
  );

  typedef struct {
    logic [79:0] word;
    int unsigned done_edge;
    int unsigned lat_mode;  // 0 none, 1 one edge (two after align), 2 must be align-delayed
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned nvec = 0, nfail = 0;
  int unsigned cyc = 0, acnt = 0, ndata = 0, lat = 0;
  bit          exp_align = 0, exp_txr = 0, mon_on = 0, prev_align = 0, lat_ok = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference alignment slot model: which edge should load an align word.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      acnt      <= 0;
      exp_align <= 1'b0;
      exp_txr   <= 1'b0;
    end else begin
      exp_txr   <= tx_ready;
      exp_align <= tx_ready && (acnt == AP - 1);
      if (tx_ready) acnt <= (acnt == AP - 1) ? 0 : acnt + 1;
    end
  end

  // Monitor: classify every output word and check it against the scoreboard.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("align_slot", 80'(GTH_DATA[79:72] == HDR_ALIGN), 80'(exp_align));
      if (exp_align) begin
        chk("align_word", GTH_DATA, {HDR_ALIGN, {9{8'hBC}}});
      end else if (word_is_data) begin
        chk("data_needs_tx_ready", 80'(exp_txr), 80'(1));
        if (sb.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_data: got %h expected no data word", GTH_DATA);
        end else begin
          mon_e = sb.pop_front();
          chk("data_word", GTH_DATA, mon_e.word);
          lat = cyc - mon_e.done_edge;
          if (mon_e.lat_mode == 1) begin
            lat_ok = (lat == 1) || (lat == 2 && prev_align);
            chk("latency", 80'(lat_ok), 80'(1));
          end else if (mon_e.lat_mode == 2) begin
            chk("latency_align_delay", 80'(lat), 80'(2));
            chk("delayed_by_align", 80'(prev_align), 80'(1));
          end
        end
        ndata++;
      end else begin
        chk("idle_word", GTH_DATA, {HDR_IDLE, ndata[15:0], 56'h0});
      end
      chk("word_cnt", 80'(word_cnt), 80'(ndata[15:0]));
      prev_align = exp_align;
    end
  end

  task automatic beat(input logic [3:0] d);
    cmp_valid = 1'b1;
    cmp_data  = d;
    @(negedge clk);
    cmp_valid = 1'b0;
    cmp_data  = '0;
  endtask

  task automatic push_exp(input logic [71:0] p, input int unsigned mode);
    exp_t e;
    e.word      = {HDR_DATA, p};
    e.done_edge = cyc;
    e.lat_mode  = mode;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", 80'(sb.size()), 80'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] p3;
    reset = 1'b1; enable = 1'b0; tx_ready = 1'b0;
    cmp_valid = 1'b0; cmp_data = '0; ch_mask = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset_gth",      GTH_DATA,            {8'h3C, 72'h0});
    chk("reset_is_data",  80'(word_is_data),   80'(0));
    chk("reset_word_cnt", 80'(word_cnt),       80'(0));
    chk("reset_overflow", 80'(overflow),       80'(0));
    chk("reset_beat_cnt", 80'(beat_cnt),       80'(0));
    reset  = 1'b0;
    mon_on = 1'b1;

    // All-ones word
    tx_ready = 1'b1; enable = 1'b1;
    @(negedge clk);
    repeat (18) beat(4'hF);
    push_exp({72{1'b1}}, 1);
    chk("beat_cnt_wrap", 80'(beat_cnt), 80'(0));
    wait_drain();
    repeat (3) @(negedge clk);

    // Per-beat ordering with channel mask 0101
    ch_mask = 4'b0101;
    for (int k = 0; k < 18; k++) p3[4*k +: 4] = 4'(k) & 4'h5;
    for (int k = 0; k < 18; k++) beat(4'(k));
    push_exp(p3, 1);
    ch_mask = 4'hF;
    wait_drain();

    // Partial word discarded by enable low
    repeat (10) beat(4'h3);
    chk("partial_beat_cnt", 80'(beat_cnt), 80'(10));
    enable = 1'b0;
    @(negedge clk);
    chk("disable_clears_cnt", 80'(beat_cnt), 80'(0));
    enable = 1'b1;
    repeat (18) beat(4'hA);
    push_exp({18{4'hA}}, 1);
    wait_drain();
    repeat (4) @(negedge clk);

    // Overflow while tx not ready: first payload kept, second dropped
    tx_ready = 1'b0;
    @(negedge clk);
    repeat (18) beat(4'h7);
    push_exp({18{4'h7}}, 0);
    chk("no_overflow_first", 80'(overflow), 80'(0));
    repeat (18) beat(4'h9);
    chk("overflow_set", 80'(overflow), 80'(1));
    repeat (5) @(negedge clk);
    tx_ready = 1'b1;
    wait_drain();
    repeat (20) @(negedge clk);
    chk("overflow_sticky", 80'(overflow), 80'(1));

    // Payload completing right before an align slot slips by one word
    repeat (17) beat(4'h6);
    for (int i = 0; i < 20; i++) begin
      if (acnt == AP - 2) break;
      @(negedge clk);
    end
    beat(4'h6);
    push_exp({18{4'h6}}, 2);
    wait_drain();
    repeat (20) @(negedge clk);

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
